// File: rtl/ucode_pkg.sv
// Shared types and sizes for the control-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ucode_pkg;

  localparam int AW       = 8;            // control-memory address width
  localparam int DW       = 32;           // microinstruction width
  localparam int BW       = 8;            // host byte width
  localparam int BPW      = DW / BW;      // bytes per microinstruction
  localparam int CM_DEPTH = 1 << AW;      // control-memory words
  localparam int IDXW     = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_WRITE    = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/ucode_byte_packer.sv
// Packs host bytes little-endian into one microinstruction word.
// Latency: byte visible in o_word the cycle after i_push; o_word_full is combinational.
// Backpressure: none internally; the caller gates i_push with its own handshake.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : return byte index to 0 (word contents are kept)
//   i_push, i_byte : store i_byte at the current byte index
//   o_word         : assembled word (holds its value when not pushing)
//   o_word_full    : i_push is landing the last byte of a word this cycle
module ucode_byte_packer
  import ucode_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic [BW-1:0] i_byte,
  output logic [DW-1:0] o_word,
  output logic          o_word_full
);

  logic [IDXW-1:0] r_idx;
  logic [DW-1:0]   r_word;
  logic            w_last;

  assign w_last      = (r_idx == IDXW'(BPW - 1));
  assign o_word_full = i_push && w_last;
  assign o_word      = r_word;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      // Clear wins: an aborted partial word must not advance the index.
      r_idx <= '0;
    end else if (i_push) begin
      r_word[BW*r_idx +: BW] <= i_byte;
      r_idx                  <= w_last ? '0 : r_idx + IDXW'(1);
    end
  end

endmodule

// File: rtl/ucode_load_ctrl.sv
// Run-time loader/arbiter for the microsequencer control memory: holds the CPU,
// packs host bytes into words and writes them to consecutive addresses.
// Latency: >= BPW+1 cycles per word; DONE adds one restart cycle at the end of a load.
// Backpressure: rx_ready only in ASSEMBLE; the host stalls freely via rx_valid.
//
// Ports:
//   CLK, RST                         : clock, async active-low reset
//   load_req/load_base/load_count    : start a load (sampled in IDLE only)
//   load_abort                       : end a load early (ASSEMBLE/WRITE only)
//   rx_valid/rx_data/rx_ready        : host byte stream
//   car                              : sequencer address, routed to cm_a in IDLE
//   cm_a/cm_d/cm_we                  : control-memory write/address port
//   cpu_hold/seq_restart/busy        : sequencer control and status
//   words_done                       : words written by the current/last load
module ucode_load_ctrl
  import ucode_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_req,
  input  logic [AW-1:0] load_base,
  input  logic [AW:0]   load_count,
  input  logic          load_abort,
  input  logic          rx_valid,
  input  logic [BW-1:0] rx_data,
  output logic          rx_ready,
  input  logic [AW-1:0] car,
  output logic [AW-1:0] cm_a,
  output logic [DW-1:0] cm_d,
  output logic          cm_we,
  output logic          cpu_hold,
  output logic          seq_restart,
  output logic          busy,
  output logic [AW:0]   words_done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW-1:0] r_wr_addr;
  logic [AW:0]   r_remaining;
  logic [AW:0]   r_words_done;

  logic w_start;
  logic w_push;
  logic w_clear;
  logic w_word_full;
  logic w_last_word;

  // Handshake is derived from state directly so the packer path never
  // loops back through the output decode below.
  assign w_start     = (r_state == ST_IDLE) && load_req && (load_count != '0);
  assign w_push      = (r_state == ST_ASSEMBLE) && rx_valid && !load_abort;
  assign w_clear     = w_start || ((r_state == ST_ASSEMBLE) && load_abort);
  assign w_last_word = (r_remaining == (AW+1)'(1));

  ucode_byte_packer u_packer (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_clear     (w_clear),
    .i_push      (w_push),
    .i_byte      (rx_data),
    .o_word      (cm_d),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    rx_ready    = 1'b0;
    cm_we       = 1'b0;
    cpu_hold    = 1'b1;
    seq_restart = 1'b0;
    busy        = 1'b1;
    cm_a        = r_wr_addr;
    case (r_state)
      ST_IDLE: begin
        cpu_hold = 1'b0;
        busy     = 1'b0;
        cm_a     = car;
        if (w_start) w_state_nxt = ST_ASSEMBLE;
      end
      ST_ASSEMBLE: begin
        rx_ready = 1'b1;
        if (load_abort)       w_state_nxt = ST_DONE;
        else if (w_word_full) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        cm_we = 1'b1;
        // An abort here still lets this word land; only the next one is skipped.
        if (load_abort || w_last_word) w_state_nxt = ST_DONE;
        else                           w_state_nxt = ST_ASSEMBLE;
      end
      ST_DONE: begin
        seq_restart = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_wr_addr    <= '0;
      r_remaining  <= '0;
      r_words_done <= '0;
    end else if (w_start) begin
      r_wr_addr    <= load_base;
      r_remaining  <= load_count;
      r_words_done <= '0;
    end else if (r_state == ST_WRITE) begin
      // Address wraps modulo the memory depth by natural overflow.
      r_wr_addr    <= r_wr_addr + AW'(1);
      r_remaining  <= r_remaining - (AW+1)'(1);
      r_words_done <= r_words_done + (AW+1)'(1);
    end
  end

  assign words_done = r_words_done;

endmodule
